// File: rtl/mutex_sched_pkg.sv
// -----------------------------------------------------------------------------
// mutex_sched_pkg
// Shared definitions for the mutual-exclusion scheduler slice: FSM state
// encoding, LFSR feedback taps, default parameter values and the LFSR
// next-state helper used by lfsr16.
// -----------------------------------------------------------------------------
package mutex_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FORCE = 2'd2
    } sched_state_t;

    localparam int          DEF_MAX_WAIT  = 4;
    localparam int          DEF_PAUSE_MAX = 3;
    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage : mutex_sched_pkg

// File: rtl/mutex_scheduler_if.sv
// -----------------------------------------------------------------------------
// mutex_scheduler_if
// Step-request / step-result bundle between a controller (master) and the
// scheduler (slave).
//   enable, mode, ext_sel, ext_pause : master -> slave step request
//   select, pause, forced            : slave -> master registered step result
//   wait_cnt0, wait_cnt1             : slave -> master unselected-step counts
// -----------------------------------------------------------------------------
interface mutex_scheduler_if
    import mutex_sched_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic             enable;
    logic             mode;
    logic             ext_sel;
    logic             ext_pause;
    logic             select;
    logic             pause;
    logic             forced;
    logic [CNT_W-1:0] wait_cnt0;
    logic [CNT_W-1:0] wait_cnt1;

    modport master (
        output enable, mode, ext_sel, ext_pause,
        input  select, pause, forced, wait_cnt0, wait_cnt1
    );

    modport slave (
        input  enable, mode, ext_sel, ext_pause,
        output select, pause, forced, wait_cnt0, wait_cnt1
    );

endinterface : mutex_scheduler_if

// File: rtl/mutex_scheduler_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR (taps 16,14,13,11), advanced only when requested.
//   clock   : sole clock, posedge
//   reset_n : asynchronous active-low reset, loads the seed
//   advance : 1 = shift one step this cycle
//   seed    : reset value; an all-zero seed is replaced by 16'h0001
//   state   : current register contents
// -----------------------------------------------------------------------------
module lfsr16
    import mutex_sched_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] seed_eff;

    // All-zero is the lock-up state of an XOR LFSR, so never load it.
    assign seed_eff = (seed == '0) ? 16'h0001 : seed;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= seed_eff;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule : lfsr16

// File: rtl/mutex_scheduler.sv
// -----------------------------------------------------------------------------
// mutex_scheduler
// Chooses which of two processes the downstream mutual-exclusion model steps
// next, and whether that process pauses. Choices come from the bus (mode=0)
// or from an LFSR (mode=1). A process left unselected for MAX_WAIT issued
// steps is force-selected, and pause is forced low after PAUSE_MAX
// consecutive pauses, so the downstream model always makes progress.
//   clock   : sole clock, posedge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of mutex_scheduler_if (request in, registered result out)
// -----------------------------------------------------------------------------
module mutex_scheduler
    import mutex_sched_pkg::*;
#(
    parameter int          MAX_WAIT  = DEF_MAX_WAIT,
    parameter int          PAUSE_MAX = DEF_PAUSE_MAX,
    parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED
)(
    input  logic               clock,
    input  logic               reset_n,
    mutex_scheduler_if.slave   bus
);

    localparam int CNT_W  = $clog2(MAX_WAIT + 1);
    localparam int PRUN_W = $clog2(PAUSE_MAX + 1);

    localparam logic [CNT_W-1:0]  WAIT_LIM  = CNT_W'(MAX_WAIT);
    localparam logic [PRUN_W-1:0] PAUSE_LIM = PRUN_W'(PAUSE_MAX);

    sched_state_t      state;
    logic              sel_q;
    logic              pause_q;
    logic              forced_q;
    logic [CNT_W-1:0]  wait0_q;
    logic [CNT_W-1:0]  wait1_q;
    logic [PRUN_W-1:0] prun_q;

    logic [15:0]       lfsr_state;

    logic              raw_sel;
    logic              raw_pause;
    logic              starve0;
    logic              starve1;
    logic              step_sel;
    logic              step_pause;
    logic              step_forced;

    lfsr16 u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .advance (bus.enable),
        .seed    (LFSR_SEED),
        .state   (lfsr_state)
    );

    // Step decision. Only one process can be starved at a time, because the
    // selected process's counter is cleared on every issued step.
    always_comb begin
        raw_sel     = bus.mode ? lfsr_state[0] : bus.ext_sel;
        raw_pause   = bus.mode ? lfsr_state[1] : bus.ext_pause;
        starve0     = (wait0_q == WAIT_LIM);
        starve1     = (wait1_q == WAIT_LIM);
        step_forced = starve0 | starve1;
        step_sel    = raw_sel;
        if (starve0) begin
            step_sel = 1'b0;
        end else if (starve1) begin
            step_sel = 1'b1;
        end
        step_pause  = (prun_q == PAUSE_LIM) ? 1'b0 : raw_pause;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            sel_q    <= 1'b0;
            pause_q  <= 1'b1;
            forced_q <= 1'b0;
            wait0_q  <= '0;
            wait1_q  <= '0;
            prun_q   <= '0;
        end else if (!bus.enable) begin
            // Idle: hold the process, keep it paused, freeze all counters.
            state    <= ST_IDLE;
            pause_q  <= 1'b1;
            forced_q <= 1'b0;
        end else begin
            sel_q    <= step_sel;
            pause_q  <= step_pause;
            forced_q <= step_forced;

            if (step_sel) begin
                wait1_q <= '0;
                wait0_q <= (wait0_q == WAIT_LIM) ? wait0_q : wait0_q + 1'b1;
            end else begin
                wait0_q <= '0;
                wait1_q <= (wait1_q == WAIT_LIM) ? wait1_q : wait1_q + 1'b1;
            end

            prun_q <= step_pause ? prun_q + 1'b1 : '0;

            case (state)
                ST_IDLE:  state <= ST_RUN;
                ST_RUN:   state <= step_forced ? ST_FORCE : ST_RUN;
                ST_FORCE: state <= ST_RUN;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign bus.select    = sel_q;
    assign bus.pause     = pause_q;
    assign bus.forced    = forced_q;
    assign bus.wait_cnt0 = wait0_q;
    assign bus.wait_cnt1 = wait1_q;

endmodule : mutex_scheduler

// File: tb/tb_mutex_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mutex_scheduler
// Directed bench for mutex_scheduler with MAX_WAIT=4, PAUSE_MAX=3,
// seed 16'hACE1. Inputs change after the sampling point, outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mutex_scheduler;
    import mutex_sched_pkg::*;

    localparam int          TB_MAX_WAIT  = 4;
    localparam int          TB_PAUSE_MAX = 3;
    localparam logic [15:0] TB_SEED      = 16'hACE1;

    logic clock;
    logic reset_n;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state for the LFSR-mode run
    logic [15:0] m_lfsr;
    logic        m_sel, m_pause, m_forced;
    int          m_w0, m_w1, m_prun;

    mutex_scheduler_if #(.MAX_WAIT(TB_MAX_WAIT)) bus ();

    mutex_scheduler #(
        .MAX_WAIT  (TB_MAX_WAIT),
        .PAUSE_MAX (TB_PAUSE_MAX),
        .LFSR_SEED (TB_SEED)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic sel, input logic pau, input logic frc,
                           input int w0, input int w1);
        check_eq({tag, ".select"},    32'(bus.select),    32'(sel));
        check_eq({tag, ".pause"},     32'(bus.pause),     32'(pau));
        check_eq({tag, ".forced"},    32'(bus.forced),    32'(frc));
        check_eq({tag, ".wait_cnt0"}, 32'(bus.wait_cnt0), w0);
        check_eq({tag, ".wait_cnt1"}, 32'(bus.wait_cnt1), w1);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        bus.enable    = 1'b0;
        bus.mode      = 1'b0;
        bus.ext_sel   = 1'b0;
        bus.ext_pause = 1'b0;
        reset_n       = 1'b0;
        #2;
        reset_n       = 1'b1;
    endtask

    function automatic logic [15:0] gold_lfsr(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    // One step of the scheduler as described by its requirements.
    task automatic model_step(input logic en);
        logic rs, rp;
        if (!en) begin
            m_pause  = 1'b1;
            m_forced = 1'b0;
        end else begin
            rs = m_lfsr[0];
            rp = m_lfsr[1];
            m_forced = (m_w0 == TB_MAX_WAIT) || (m_w1 == TB_MAX_WAIT);
            if (m_w0 == TB_MAX_WAIT)      m_sel = 1'b0;
            else if (m_w1 == TB_MAX_WAIT) m_sel = 1'b1;
            else                          m_sel = rs;
            m_pause = (m_prun == TB_PAUSE_MAX) ? 1'b0 : rp;
            m_prun  = m_pause ? m_prun + 1 : 0;
            if (m_sel) begin
                m_w1 = 0;
                if (m_w0 < TB_MAX_WAIT) m_w0++;
            end else begin
                m_w0 = 0;
                if (m_w1 < TB_MAX_WAIT) m_w1++;
            end
            m_lfsr = gold_lfsr(m_lfsr);
        end
    endtask

    initial begin
        logic [15:0] exp_lfsr;
        int          period;
        logic        pseq [8];

        bus.enable    = 1'b0;
        bus.mode      = 1'b0;
        bus.ext_sel   = 1'b0;
        bus.ext_pause = 1'b0;
        reset_n       = 1'b1;

        // ---- reset without any clock edge ----
        #1 reset_n = 1'b0;
        #1;
        chk_out("rst_async", 1'b0, 1'b1, 1'b0, 0, 0);
        check_eq("rst_async.state", 32'(dut.state), 32'(ST_IDLE));
        #1 reset_n = 1'b1;

        // ---- starvation: ext_sel held at 0 ----
        do_reset();
        bus.enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_out($sformatf("starve.s%0d", i), 1'b0, 1'b0, 1'b0, 0, i);
        end
        tick();
        chk_out("starve.s5", 1'b1, 1'b0, 1'b1, 1, 0);
        check_eq("starve.s5.state", 32'(dut.state), 32'(ST_FORCE));
        tick();
        chk_out("starve.s6", 1'b0, 1'b0, 1'b0, 0, 1);
        check_eq("starve.s6.state", 32'(dut.state), 32'(ST_RUN));

        // ---- async reset mid-run during FORCE ----
        tick(); tick(); tick();   // wait_cnt1 now 4
        tick();                   // forced step, state FORCE
        chk_out("midrst.pre", 1'b1, 1'b0, 1'b1, 1, 0);
        check_eq("midrst.pre.state", 32'(dut.state), 32'(ST_FORCE));
        #2 reset_n = 1'b0;
        #1;
        chk_out("midrst.low", 1'b0, 1'b1, 1'b0, 0, 0);
        check_eq("midrst.low.state", 32'(dut.state), 32'(ST_IDLE));
        #1 reset_n = 1'b1;
        tick();
        chk_out("midrst.first", 1'b0, 1'b0, 1'b0, 0, 1);
        check_eq("midrst.first.state", 32'(dut.state), 32'(ST_RUN));

        // ---- pause limit: ext_pause held at 1 ----
        do_reset();
        pseq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.enable    = 1'b1;
        bus.ext_pause = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.ext_sel = i[0];
            tick();
            check_eq($sformatf("pause.s%0d", i + 1), 32'(bus.pause), 32'(pseq[i]));
        end

        // ---- enable drop with wait_cnt0=2 ----
        do_reset();
        bus.enable  = 1'b1;
        bus.ext_sel = 1'b1;
        tick(); tick();
        chk_out("endrop.pre", 1'b1, 1'b0, 1'b0, 2, 0);
        bus.enable  = 1'b0;
        bus.ext_sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out($sformatf("endrop.idle%0d", i), 1'b1, 1'b1, 1'b0, 2, 0);
            check_eq($sformatf("endrop.idle%0d.state", i), 32'(dut.state), 32'(ST_IDLE));
        end
        exp_lfsr = gold_lfsr(gold_lfsr(TB_SEED));
        check_eq("endrop.lfsr_hold", 32'(dut.u_lfsr.state), 32'(exp_lfsr));

        // ---- LFSR mode vs golden model, with one idle cycle ----
        do_reset();
        m_lfsr = TB_SEED; m_sel = 1'b0; m_pause = 1'b1; m_forced = 1'b0;
        m_w0 = 0; m_w1 = 0; m_prun = 0;
        bus.mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.enable = (i != 150);
            model_step(bus.enable);
            tick();
            chk_out($sformatf("lfsr.s%0d", i), m_sel, m_pause, m_forced, m_w0, m_w1);
        end

        // ---- LFSR period ----
        do_reset();
        bus.mode   = 1'b1;
        bus.enable = 1'b1;
        period = 0;
        for (int i = 1; i <= 70000; i++) begin
            tick();
            period = i;
            if (dut.u_lfsr.state == TB_SEED) break;
        end
        check_eq("lfsr.period", period, 65535);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mutex_scheduler

// File: doc/mutex_scheduler.md
MUTEX_SCHEDULER -- requirements
Module: mutex_scheduler

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, max consecutive issued steps a process may go unselected (legal >= 1).
REQ-002 SHALL have parameter PAUSE_MAX, default 3, max consecutive issued steps with pause=1 (legal >= 1).
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, LFSR reset value; a seed of 0 is replaced by 16'h0001.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  1 = issue one scheduling step this cycle.
REQ-007 SHALL have port mode  input  1  0 = external choices, 1 = LFSR-driven choices.
REQ-008 SHALL have port ext_sel  input  1  requested process index, used when mode=0.
REQ-009 SHALL have port ext_pause  input  1  requested pause, used when mode=0.
REQ-010 SHALL have port select  output  1  process index stepped by the downstream mutual-exclusion model.
REQ-011 SHALL have port pause  output  1  pause to the downstream model; holds a process in its noncritical or critical section.
REQ-012 SHALL have port forced  output  1  1 = the current select came from a starvation override.
REQ-013 SHALL have port wait_cnt0 / wait_cnt1  output  $clog2(MAX_WAIT+1)  unselected-step count per process.

Function
REQ-014 SHALL register all outputs; a choice sampled at posedge N appears at outputs after posedge N (latency 1).
REQ-015 SHALL implement FSM states IDLE, RUN, FORCE: IDLE->RUN when enable=1; RUN->FORCE when the step selects a starved process; FORCE->RUN after one step; any state->IDLE when enable=0.
REQ-016 SHALL compute the raw choice as sel = ext_sel and pause = ext_pause when mode=0, and as sel = lfsr[0] and pause = lfsr[1] when mode=1.
REQ-017 SHALL advance a 16-bit Fibonacci LFSR (taps 16,14,13,11) once per enabled cycle in either mode, and hold it when enable=0.
REQ-018 SHALL override sel to process p, and set forced=1, when wait_cnt_p == MAX_WAIT at the step; otherwise forced=0.
REQ-019 SHALL clear the selected process's wait counter to 0 and increment the other, saturating at MAX_WAIT, on each issued step.
REQ-020 SHALL keep a pause-run counter that increments on each issued pause=1 and clears on each issued pause=0.
REQ-021 SHALL force pause=0 on a step when the pause-run counter == PAUSE_MAX.
REQ-022 SHALL apply the starvation override and the pause override independently when both trigger in the same step.
REQ-023 SHALL, when enable=0, drive pause=1 and forced=0, hold select, and freeze all counters.
REQ-024 SHALL guarantee that no process goes unselected for more than MAX_WAIT consecutive issued steps, in either mode.

Reset
REQ-025 SHALL, while reset_n=0 and without waiting for a clock edge, set select=0, pause=1, forced=0, wait_cnt0=wait_cnt1=0, pause-run counter=0, LFSR=seed, and FSM=IDLE.
REQ-026 SHALL, when reset is asserted mid-operation, discard the in-flight step; the first step after deassertion is taken at the first posedge with reset_n=1 and enable=1.

Structure
REQ-027 SHALL place the FSM state enum, the LFSR tap constant and the default parameter values in shared package mutex_sched_pkg.
REQ-028 SHALL implement the LFSR as sub-module lfsr16, with ports clock, reset_n, advance, seed, and state[15:0].

Verification
REQ-029 SHALL cover reset: reset_n=0 -> select=0, pause=1, forced=0, both counters 0, FSM=IDLE, with no clock edge needed.
REQ-030 SHALL cover starvation: MAX_WAIT=4, mode=0, ext_sel=0 held -> select=0 for 4 steps, then select=1 with forced=1 on step 5, then wait_cnt1=0.
REQ-031 SHALL cover the pause limit: PAUSE_MAX=3, ext_pause=1 held -> pause sequence 1,1,1,0,1,1,1,0.
REQ-032 SHALL cover enable drop: enable 1->0 with wait_cnt0=2 -> pause=1, select unchanged, wait_cnt0 stays 2, FSM=IDLE.
REQ-033 SHALL cover LFSR mode: seed 16'hACE1, mode=1 -> select/pause match a golden LFSR model bit-for-bit (override steps excepted), and the period is 65535.
REQ-034 SHALL cover async reset mid-run: reset_n pulsed low between edges during FORCE -> outputs return to reset values immediately and the next step is unforced.
